// File: rtl/tiny_riscv_lsu.sv
// Load/store unit for a tiny RV32 core: one access at a time, IDLE->ISSUE->(WAIT)->DONE.
// Define TINY_RISCV_LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.
module tiny_riscv_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_misaligned,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_read_strobe,
  input  logic [31:0]           i_mem_data,
  output logic [31:0]           o_mem_write_data,
  output logic [3:0]            o_mem_write_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_go;
  logic        r_trap;

  logic        w_valid;
  logic        w_trap;
  logic        w_go;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Decode of the incoming request; only consumed on the accept edge.
  // NOTE: every output of an always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    w_valid = i_we ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                   : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (i_funct3[1:0])
      2'b00: begin
        w_off   = i_addr[1:0];
        w_mask  = 4'b0001 << i_addr[1:0];
        w_wdata = {24'b0, i_wdata[7:0]} << {i_addr[1:0], 3'b000};
      end
      2'b01: begin
        w_off   = {i_addr[1], 1'b0};
        w_mask  = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata = {16'b0, i_wdata[15:0]} << {i_addr[1], 4'b0000};
      end
      default: begin
        w_off   = 2'b00;
        w_mask  = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_trap  = w_valid & w_misal;
`else
  // Misaligned halfword/word accesses are silently rounded down via w_off.
  assign w_trap  = 1'b0;
`endif

  assign w_go = w_valid & ~w_trap;

  // Lane extraction for the load result, driven from the registered operands.
  always_comb begin
    w_shifted = i_mem_data >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = w_shifted;
      3'b100:  w_load = {24'b0, w_shifted[7:0]};
      3'b101:  w_load = {16'b0, w_shifted[15:0]};
      default: w_load = 32'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state           <= S_IDLE;
      r_we              <= 1'b0;
      r_funct3          <= 3'b000;
      r_off             <= 2'b00;
      r_go              <= 1'b0;
      r_trap            <= 1'b0;
      o_ready           <= 1'b1;
      o_done            <= 1'b0;
      o_rdata           <= 32'b0;
      o_misaligned      <= 1'b0;
      o_mem_addr        <= '0;
      o_mem_read_strobe <= 1'b0;
      o_mem_write_data  <= 32'b0;
      o_mem_write_mask  <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_state           <= S_ISSUE;
            r_we              <= i_we;
            r_funct3          <= i_funct3;
            r_off             <= w_off;
            r_go              <= w_go;
            r_trap            <= w_trap;
            o_ready           <= 1'b0;
            o_mem_addr        <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            o_mem_read_strobe <= w_go & ~i_we;
            o_mem_write_mask  <= (w_go & i_we) ? w_mask : 4'b0000;
            o_mem_write_data  <= (w_go & i_we) ? w_wdata : 32'b0;
          end
        end
        S_ISSUE: begin
          o_mem_read_strobe <= 1'b0;
          o_mem_write_mask  <= 4'b0000;
          o_mem_write_data  <= 32'b0;
          if (r_go && !r_we) begin
            r_state <= S_WAIT;
          end else begin
            r_state      <= S_DONE;
            o_done       <= 1'b1;
            o_misaligned <= r_trap;
            // Unsupported loads return zero; traps and stores leave o_rdata alone.
            if (!r_we && !r_go && !r_trap) begin
              o_rdata <= 32'b0;
            end
          end
        end
        S_WAIT: begin
          r_state <= S_DONE;
          o_done  <= 1'b1;
          o_rdata <= w_load;
        end
        default: begin
          r_state      <= S_IDLE;
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
          o_ready      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_riscv_lsu.sv
// Self-checking bench for tiny_riscv_lsu: transaction-level model compared every cycle,
// plus directed loads/stores with hand-computed results.
module tb_tiny_riscv_lsu;

`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_ready;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic [31:0] o_mem_addr;
  logic        o_mem_read_strobe;
  logic [31:0] mem_q = 32'h0;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_write_mask;

  int total = 0;
  int bad = 0;

  tiny_riscv_lsu #(.ADDR_WIDTH(32)) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_req            (i_req),
    .i_we             (i_we),
    .i_funct3         (i_funct3),
    .i_addr           (i_addr),
    .i_wdata          (i_wdata),
    .o_ready          (o_ready),
    .o_done           (o_done),
    .o_rdata          (o_rdata),
    .o_misaligned     (o_misaligned),
    .o_mem_addr       (o_mem_addr),
    .o_mem_read_strobe(o_mem_read_strobe),
    .i_mem_data       (mem_q),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_write_mask (o_mem_write_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- memory and reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'h40:  return 32'h8899AABB;
      30'h41:  return 32'h01234567;
      30'h80:  return 32'h7F0180FF;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (o_mem_read_strobe) mem_q <= mem_word(o_mem_addr);
  end

  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit valid_op(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % sz(f3)) != 0;
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a[1:0]);
    return o - (o % sz(f3));
  endfunction

  function automatic bit go_op(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return valid_op(we, f3) && !(TRAP && misal(f3, a));
  endfunction

  function automatic int lat_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return (!we && go_op(we, f3, a)) ? 3 : 2;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a);
    int s = sz(f3);
    logic [31:0] v = w >> (8 * eff_off(f3, a));
    logic [31:0] keep;
    if (s < 4) begin
      keep = (32'h1 << (8 * s)) - 32'h1;
      v = v & keep;
      if (!f3[2] && v[8*s-1]) v = v | ~keep;
    end
    return v;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0;
    int o = eff_off(f3, a);
    for (int k = 0; k < 4; k++) if (k >= o && k < o + sz(f3)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] wd);
    logic [31:0] d = 32'h0;
    int o = eff_off(f3, a);
    for (int k = 0; k < 4; k++) if (k >= o && k < o + sz(f3)) d[8*k +: 8] = wd[8*(k-o) +: 8];
    return d;
  endfunction

  // ph counts cycles since the accept edge (0 = idle); done when ph equals the op latency.
  int          ph = 0;
  logic        m_we = 1'b0;
  logic [2:0]  m_f3 = 3'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= 0;
      m_rdata <= 32'h0;
    end else if (ph == 0) begin
      if (i_req) begin
        ph      <= 1;
        m_we    <= i_we;
        m_f3    <= i_funct3;
        m_addr  <= i_addr;
        m_wdata <= i_wdata;
      end
    end else if (ph == lat_of(m_we, m_f3, m_addr)) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
      if (ph + 1 == lat_of(m_we, m_f3, m_addr) && !m_we) begin
        if (!valid_op(m_we, m_f3))
          m_rdata <= 32'h0;
        else if (go_op(m_we, m_f3, m_addr))
          m_rdata <= load_val(mem_word(m_addr), m_f3, m_addr);
      end
    end
  end

  always @(negedge clk) begin
    logic e_done, e_issue_st;
    e_done     = (ph != 0) && (ph == lat_of(m_we, m_f3, m_addr));
    e_issue_st = (ph == 1) && m_we && go_op(m_we, m_f3, m_addr);
    check("ready", {31'b0, o_ready}, {31'b0, ph == 0});
    check("done", {31'b0, o_done}, {31'b0, e_done});
    check("strobe", {31'b0, o_mem_read_strobe},
          {31'b0, (ph == 1) && !m_we && go_op(m_we, m_f3, m_addr)});
    check("mask", {28'b0, o_mem_write_mask}, {28'b0, e_issue_st ? store_mask(m_f3, m_addr) : 4'b0});
    check("rdata", o_rdata, m_rdata);
    if (ph == 1) check("mem_addr", o_mem_addr, {m_addr[31:2], 2'b00});
    if (e_issue_st) check("wdata", o_mem_write_data, store_data(m_f3, m_addr, m_wdata));
    if (!rst_n) begin
      check("rst_wdata", o_mem_write_data, 32'h0);
      check("rst_mem_addr", o_mem_addr, 32'h0);
    end
    if (!TRAP || e_done)
      check("misaligned", {31'b0, o_misaligned},
            {31'b0, e_done && TRAP && valid_op(m_we, m_f3) && misal(m_f3, m_addr)});
  end

  // Records the last write seen on the memory port.
  int          wr_cnt = 0;
  logic [3:0]  wr_mask = 4'b0;
  logic [31:0] wr_data = 32'h0;
  always @(negedge clk) begin
    if (o_mem_write_mask != 4'b0) begin
      wr_cnt++;
      wr_mask = o_mem_write_mask;
      wr_data = o_mem_write_data;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
    int n = 0;
    @(posedge clk); #1;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) timeout_fail("ready_wait");
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge clk); #1;
    i_req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_done && lat < 12);
    if (!o_done) timeout_fail("done_wait");
  endtask

  initial begin
    int lat;
    int cnt;
    int w0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, o_ready}, 32'h1);
    check("reset_done", {31'b0, o_done}, 32'h0);
    check("reset_rdata", o_rdata, 32'h0);
    check("reset_mask", {28'b0, o_mem_write_mask}, 32'h0);
    rst_n = 1'b1;

    do_op(1'b0, 3'b000, 32'h101, 32'h0, lat);
    check("lb_lat", lat, 3);
    check("lb_101", o_rdata, 32'hFFFFFFAA);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, lat);
    check("lbu_103", o_rdata, 32'h00000088);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, lat);
    check("lhu_102", o_rdata, 32'h00008899);
    do_op(1'b0, 3'b001, 32'h100, 32'h0, lat);
    check("lh_100", o_rdata, 32'hFFFFAABB);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, lat);
    check("lw_100", o_rdata, 32'h8899AABB);

    w0 = wr_cnt;
    do_op(1'b1, 3'b000, 32'h102, 32'h12345678, lat);
    check("sb_lat", lat, 2);
    check("sb_writes", wr_cnt - w0, 1);
    check("sb_mask", {28'b0, wr_mask}, 32'h4);
    check("sb_data", wr_data, 32'h00780000);
    check("sb_keeps_rdata", o_rdata, 32'h8899AABB);
    do_op(1'b1, 3'b001, 32'h102, 32'h0000CAFE, lat);
    check("sh_mask", {28'b0, wr_mask}, 32'hC);
    check("sh_data", wr_data, 32'hCAFE0000);
    do_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, lat);
    check("sw_mask", {28'b0, wr_mask}, 32'hF);
    check("sw_data", wr_data, 32'hDEADBEEF);

    do_op(1'b0, 3'b000, 32'h201, 32'h0, lat);
    check("lb_201", o_rdata, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h200, 32'h0, lat);
    check("lbu_200", o_rdata, 32'h000000FF);
    do_op(1'b0, 3'b001, 32'h202, 32'h0, lat);
    check("lh_202", o_rdata, 32'h00007F01);

    do_op(1'b0, 3'b011, 32'h100, 32'h0, lat);
    check("bad_load_lat", lat, 2);
    check("bad_load_rdata", o_rdata, 32'h0);
    w0 = wr_cnt;
    do_op(1'b1, 3'b100, 32'h100, 32'h11223344, lat);
    check("bad_store_lat", lat, 2);
    check("bad_store_writes", wr_cnt - w0, 0);

    do_op(1'b0, 3'b010, 32'h101, 32'h0, lat);
`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
    check("lw_101_lat", lat, 2);
    check("lw_101_mis", {31'b0, o_misaligned}, 32'h1);
    check("lw_101_rdata", o_rdata, 32'h0);
`else
    check("lw_101_lat", lat, 3);
    check("lw_101_mis", {31'b0, o_misaligned}, 32'h0);
    check("lw_101_rdata", o_rdata, 32'h8899AABB);
`endif
    w0 = wr_cnt;
    do_op(1'b1, 3'b001, 32'h101, 32'h0000CAFE, lat);
`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
    check("sh_101_writes", wr_cnt - w0, 0);
    check("sh_101_mis", {31'b0, o_misaligned}, 32'h1);
`else
    check("sh_101_mask", {28'b0, wr_mask}, 32'h3);
    check("sh_101_data", wr_data, 32'h0000CAFE);
`endif

    // Request held for 10 cycles: loads take 4 cycles each, so 3 accepts.
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h100;
    cnt = 0;
    repeat (11) begin
      @(negedge clk);
      if (o_mem_read_strobe) cnt++;
    end
    i_req = 1'b0;
    check("held_req_accepts", cnt, 3);
    lat = 0;
    while (!o_done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!o_done) timeout_fail("held_req_drain");

    // Reset pulsed while a load waits for memory.
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h100;
    @(posedge clk); #1;
    i_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_strobe", {31'b0, o_mem_read_strobe}, 32'h0);
    check("abort_mask", {28'b0, o_mem_write_mask}, 32'h0);
    check("abort_ready", {31'b0, o_ready}, 32'h1);
    check("abort_done", {31'b0, o_done}, 32'h0);
    check("abort_rdata", o_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b000; i_addr = 32'h101;
    @(posedge clk); #1;
    i_req = 1'b0;
    check("first_edge_accept", {31'b0, o_mem_read_strobe}, 32'h1);
    lat = 1;
    while (!o_done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!o_done) timeout_fail("post_reset_done");
    check("post_reset_lb", o_rdata, 32'hFFFFFFAA);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
